// File: rtl/uart_pkg.sv
// uart_pkg: shared types, limits and small helpers for the UART receive path.
package uart_pkg;

   localparam int unsigned DATA_BITS_MIN = 5;
   localparam int unsigned DATA_BITS_MAX = 8;

   typedef enum logic [1:0] {
      PAR_NONE = 2'b00,
      PAR_EVEN = 2'b01,
      PAR_ODD  = 2'b10
   } parity_e;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP1  = 3'd4,
      S_STOP2  = 3'd5
   } rx_state_e;

   // Out-of-range word lengths fall back to the maximum.
   function automatic logic [3:0] nbits_decode(input logic [3:0] n);
      if ((n >= 4'(DATA_BITS_MIN)) && (n <= 4'(DATA_BITS_MAX))) begin
         return n;
      end
      return 4'(DATA_BITS_MAX);
   endfunction

   // The reserved code 11 behaves as no parity.
   function automatic parity_e parity_decode(input logic [1:0] p);
      case (p)
         2'b01:   return PAR_EVEN;
         2'b10:   return PAR_ODD;
         default: return PAR_NONE;
      endcase
   endfunction

   // Two-of-three majority.
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser for an asynchronous serial line plus a
// falling-edge detector on the synchronised value. Flops reset to the idle level.
module uart_rx_sync (
   input  logic Clk_i,
   input  logic Rst_ni,
   input  logic rx_i,
   output logic rx_o,
   output logic fall_c_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   // Synchroniser chain and one-cycle history for edge detection.
   always_ff @(posedge Clk_i or negedge Rst_ni) begin
      if (!Rst_ni) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         meta_q <= rx_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign rx_o     = sync_q;
   assign fall_c_o = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver. Tick is a clock enable at
// OVERSAMPLE x baud; each bit is decided by a 3-sample majority around mid-bit.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic       Clk,
   input  logic       Rst_n,
   input  logic       RxEn,
   input  logic       Rx,
   input  logic       Tick,
   input  logic [3:0] NBits,
   input  logic [1:0] Parity,
   input  logic       TwoStop,
   output logic [7:0] RxData,
   output logic       RxValid,
   output logic       ParityErr,
   output logic       FrameErr,
   output logic       BreakDet,
   output logic       Busy
);

   localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
   localparam int unsigned HALF  = OVERSAMPLE / 2;
   localparam logic [CNT_W-1:0] CNT_LO   = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF);
   localparam logic [CNT_W-1:0] CNT_HI   = CNT_W'(HALF + 1);
   localparam logic [CNT_W-1:0] CNT_ALGN = CNT_W'(HALF + 2);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(OVERSAMPLE - 1);

   logic             rx_s;
   logic             rx_fall_c;

   rx_state_e        state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       samp_q;
   logic [2:0]       bit_idx_q;
   logic [7:0]       shift_q;
   logic [3:0]       nbits_q;
   parity_e          par_mode_q;
   logic             two_stop_q;
   logic             par_acc_q;
   logic             any_one_q;
   logic             perr_pend_q;
   logic             ferr_pend_q;
   logic             brk_pend_q;

   logic [7:0]       rx_data_q;
   logic             rx_valid_q;
   logic             parity_err_q;
   logic             frame_err_q;
   logic             break_det_q;

   logic [CNT_W-1:0] cnt_inc_c;
   logic             vote_c;
   logic             vote_now_c;
   logic             last_bit_c;
   logic             done_c;
   logic             ferr_c;
   logic             brk_c;

   uart_rx_sync u_sync (
      .Clk_i    (Clk),
      .Rst_ni   (Rst_n),
      .rx_i     (Rx),
      .rx_o     (rx_s),
      .fall_c_o (rx_fall_c)
   );

   // Counter wrap, bit vote and end-of-frame status for the current tick.
   always_comb begin
      cnt_inc_c  = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
      vote_c     = maj3(samp_q[0], samp_q[1], rx_s);
      vote_now_c = RxEn && Tick && (cnt_q == CNT_HI);
      last_bit_c = ({1'b0, bit_idx_q} == (nbits_q - 4'd1));
      done_c     = vote_now_c &&
                   (((state_q == S_STOP1) && !two_stop_q) || (state_q == S_STOP2));
      ferr_c     = (state_q == S_STOP2) ? (ferr_pend_q | ~vote_c) : ~vote_c;
      brk_c      = (state_q == S_STOP2) ? brk_pend_q : (~any_one_q & ~vote_c);
   end

   // Receiver FSM with tick counter, shift register and registered status.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         samp_q       <= 2'b11;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         nbits_q      <= 4'(DATA_BITS_MAX);
         par_mode_q   <= PAR_NONE;
         two_stop_q   <= 1'b0;
         par_acc_q    <= 1'b0;
         any_one_q    <= 1'b0;
         perr_pend_q  <= 1'b0;
         ferr_pend_q  <= 1'b0;
         brk_pend_q   <= 1'b0;
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         break_det_q  <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         if (state_q == S_IDLE) begin
            // A tick on the detect cycle already counts as sample 0.
            if (RxEn && rx_fall_c) begin
               state_q     <= S_START;
               cnt_q       <= Tick ? CNT_W'(1) : '0;
               nbits_q     <= nbits_decode(NBits);
               par_mode_q  <= parity_decode(Parity);
               two_stop_q  <= TwoStop;
               bit_idx_q   <= '0;
               shift_q     <= '0;
               par_acc_q   <= 1'b0;
               any_one_q   <= 1'b0;
               perr_pend_q <= 1'b0;
               ferr_pend_q <= 1'b0;
               brk_pend_q  <= 1'b0;
            end
         end else if (!RxEn) begin
            state_q <= S_IDLE;
         end else if (Tick) begin
            cnt_q <= cnt_inc_c;
            if (cnt_q == CNT_LO) begin
               samp_q[0] <= rx_s;
            end
            if (cnt_q == CNT_MID) begin
               samp_q[1] <= rx_s;
            end
            if (vote_now_c) begin
               case (state_q)
                  S_START: begin
                     if (vote_c) begin
                        state_q <= S_IDLE;
                     end else begin
                        // Bit boundaries now sit at count 0, votes mid-bit.
                        cnt_q   <= CNT_ALGN;
                        state_q <= S_DATA;
                     end
                  end
                  S_DATA: begin
                     shift_q[bit_idx_q] <= vote_c;
                     par_acc_q          <= par_acc_q ^ vote_c;
                     any_one_q          <= any_one_q | vote_c;
                     if (last_bit_c) begin
                        state_q <= (par_mode_q == PAR_NONE) ? S_STOP1 : S_PARITY;
                     end else begin
                        bit_idx_q <= bit_idx_q + 3'd1;
                     end
                  end
                  S_PARITY: begin
                     perr_pend_q <= ((par_acc_q ^ vote_c) != (par_mode_q == PAR_ODD));
                     any_one_q   <= any_one_q | vote_c;
                     state_q     <= S_STOP1;
                  end
                  S_STOP1: begin
                     if (two_stop_q) begin
                        ferr_pend_q <= ~vote_c;
                        brk_pend_q  <= ~any_one_q & ~vote_c;
                        state_q     <= S_STOP2;
                     end
                  end
                  default: begin
                  end
               endcase
               if (done_c) begin
                  state_q      <= S_IDLE;
                  rx_valid_q   <= 1'b1;
                  rx_data_q    <= brk_c ? '0 : shift_q;
                  parity_err_q <= perr_pend_q;
                  frame_err_q  <= ferr_c | brk_c;
                  break_det_q  <= brk_c;
               end
            end
         end
      end
   end

   assign RxData    = rx_data_q;
   assign RxValid   = rx_valid_q;
   assign ParityErr = parity_err_q;
   assign FrameErr  = frame_err_q;
   assign BreakDet  = break_det_q;
   assign Busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed and randomized frames against a frame-level model.
module tb_uart_rx_core;

   localparam int OS       = 16;
   localparam int TICK_DIV = 3;
   localparam int BIT_T    = OS;

   typedef struct packed {
      logic [7:0] data;
      logic       pe;
      logic       fe;
      logic       bd;
   } rec_t;

   logic       Clk = 1'b0;
   logic       Rst_n;
   logic       RxEn;
   logic       Rx;
   logic       Tick = 1'b0;
   logic [3:0] NBits;
   logic [1:0] Parity;
   logic       TwoStop;
   logic [7:0] RxData;
   logic       RxValid;
   logic       ParityErr;
   logic       FrameErr;
   logic       BreakDet;
   logic       Busy;

   int   checks = 0;
   int   errors = 0;
   int   tdiv   = 0;
   rec_t rx_q[$];

   uart_rx_core #(.OVERSAMPLE(OS)) dut (
      .Clk       (Clk),
      .Rst_n     (Rst_n),
      .RxEn      (RxEn),
      .Rx        (Rx),
      .Tick      (Tick),
      .NBits     (NBits),
      .Parity    (Parity),
      .TwoStop   (TwoStop),
      .RxData    (RxData),
      .RxValid   (RxValid),
      .ParityErr (ParityErr),
      .FrameErr  (FrameErr),
      .BreakDet  (BreakDet),
      .Busy      (Busy)
   );

   always #5 Clk = ~Clk;

   // Tick changes on the falling edge so it is stable at every rising edge.
   always @(negedge Clk) begin
      tdiv <= (tdiv == TICK_DIV - 1) ? 0 : tdiv + 1;
      Tick <= (tdiv == TICK_DIV - 1);
   end

   // Collect every reported frame.
   always @(negedge Clk) begin
      if (Rst_n && RxValid) rx_q.push_back({RxData, ParityErr, FrameErr, BreakDet});
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ticks(input int n);
      repeat (n) begin
         @(posedge Clk);
         while (Tick !== 1'b1) @(posedge Clk);
      end
      #1;
   endtask

   task automatic drive(input logic v, input int nticks);
      Rx = v;
      wait_ticks(nticks);
   endtask

   // ---------------- reference model ----------------
   function automatic int eff_nbits(input logic [3:0] nb);
      return ((nb >= 4'd5) && (nb <= 4'd8)) ? int'(nb) : 8;
   endfunction

   function automatic logic [7:0] mask_data(input logic [7:0] d, input int n);
      logic [7:0] m = '0;
      for (int i = 0; i < n; i++) m[i] = 1'b1;
      return d & m;
   endfunction

   function automatic logic par_enabled(input logic [1:0] par);
      return (par == 2'b01) || (par == 2'b10);
   endfunction

   // Correct parity bit makes total ones even (even mode) or odd (odd mode).
   function automatic logic par_bit(input logic [7:0] dm, input logic [1:0] par, input logic flip);
      return ((^dm) ^ (par == 2'b10)) ^ flip;
   endfunction

   function automatic rec_t model(input logic [7:0] d, input logic [3:0] nb, input logic [1:0] par,
                                  input logic ts, input logic flip, input logic s1, input logic s2);
      rec_t       r;
      logic [7:0] dm;
      logic       pen;
      logic       pb;
      dm     = mask_data(d, eff_nbits(nb));
      pen    = par_enabled(par);
      pb     = par_bit(dm, par, flip);
      r.bd   = (dm == 8'h00) && (!pen || !pb) && !s1;
      r.data = r.bd ? 8'h00 : dm;
      r.pe   = pen && (((^dm) ^ pb) != (par == 2'b10));
      r.fe   = !s1 || (ts && !s2) || r.bd;
      return r;
   endfunction

   task automatic check_one(input string tag, input rec_t exp);
      rec_t r;
      chk({tag, "_count"}, 8'(rx_q.size()), 8'd1);
      if (rx_q.size() > 0) begin
         r = rx_q.pop_front();
         chk({tag, "_data"}, r.data, exp.data);
         chk({tag, "_perr"}, 8'(r.pe), 8'(exp.pe));
         chk({tag, "_ferr"}, 8'(r.fe), 8'(exp.fe));
         chk({tag, "_brk"},  8'(r.bd), 8'(exp.bd));
      end
      rx_q.delete();
   endtask

   task automatic run_frame(input string tag, input logic [7:0] d, input logic [3:0] nb,
                            input logic [1:0] par, input logic ts, input logic flip,
                            input logic s1, input logic s2, input logic scramble);
      rec_t       exp;
      logic [7:0] dm;
      int         n;
      exp = model(d, nb, par, ts, flip, s1, s2);
      n   = eff_nbits(nb);
      dm  = mask_data(d, n);
      NBits   = nb;
      Parity  = par;
      TwoStop = ts;
      rx_q.delete();
      drive(1'b0, BIT_T);
      chk({tag, "_busy_mid"}, 8'(Busy), 8'd1);
      if (scramble) begin
         NBits   = 4'($urandom_range(0, 15));
         Parity  = 2'($urandom_range(0, 3));
         TwoStop = 1'($urandom_range(0, 1));
      end
      for (int i = 0; i < n; i++) drive(dm[i], BIT_T);
      if (par_enabled(par)) drive(par_bit(dm, par, flip), BIT_T);
      drive(s1, BIT_T);
      if (ts) drive(s2, BIT_T);
      drive(1'b1, 2 * BIT_T);
      check_one(tag, exp);
      chk({tag, "_busy_end"}, 8'(Busy), 8'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      Rst_n   = 1'b0;
      RxEn    = 1'b1;
      Rx      = 1'b1;
      NBits   = 4'd8;
      Parity  = 2'b00;
      TwoStop = 1'b0;
      #1;
      chk("rst_data",  RxData,        8'h00);
      chk("rst_valid", 8'(RxValid),   8'd0);
      chk("rst_perr",  8'(ParityErr), 8'd0);
      chk("rst_ferr",  8'(FrameErr),  8'd0);
      chk("rst_brk",   8'(BreakDet),  8'd0);
      chk("rst_busy",  8'(Busy),      8'd0);
      repeat (5) @(posedge Clk);
      #1 Rst_n = 1'b1;
      wait_ticks(40);

      run_frame("8N1_A5",     8'hA5, 4'd8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      run_frame("7E1_55_bad", 8'h55, 4'd7, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      run_frame("8N2_3C_s2",  8'h3C, 4'd8, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

      // Short low glitch: false start, nothing reported.
      rx_q.delete();
      drive(1'b0, 5);
      drive(1'b1, 2 * BIT_T);
      chk("glitch_count", 8'(rx_q.size()), 8'd0);
      chk("glitch_busy",  8'(Busy),        8'd0);
      run_frame("8N1_12", 8'h12, 4'd8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

      // Break: line low for 20 bit times, then idle.
      NBits = 4'd8; Parity = 2'b00; TwoStop = 1'b0;
      rx_q.delete();
      drive(1'b0, 20 * BIT_T);
      chk("break_busy", 8'(Busy), 8'd0);
      drive(1'b1, 2 * BIT_T);
      check_one("break", '{data: 8'h00, pe: 1'b0, fe: 1'b1, bd: 1'b1});

      // Reset during DATA clears everything.
      rx_q.delete();
      drive(1'b0, BIT_T);
      drive(1'b1, 3 * BIT_T);
      chk("rstmid_busy_pre", 8'(Busy), 8'd1);
      Rst_n = 1'b0;
      #1;
      chk("rstmid_data", RxData,        8'h00);
      chk("rstmid_perr", 8'(ParityErr), 8'd0);
      chk("rstmid_ferr", 8'(FrameErr),  8'd0);
      chk("rstmid_brk",  8'(BreakDet),  8'd0);
      chk("rstmid_busy", 8'(Busy),      8'd0);
      repeat (3) @(posedge Clk);
      #1 Rst_n = 1'b1;
      drive(1'b1, 6 * BIT_T);
      chk("rstmid_count", 8'(rx_q.size()), 8'd0);
      run_frame("after_rst_FF", 8'hFF, 4'd8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

      // RxEn drop during DATA: abort, status held.
      run_frame("8O1_81_bad", 8'h81, 4'd8, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      rx_q.delete();
      drive(1'b0, BIT_T);
      drive(1'b1, 3 * BIT_T);
      RxEn = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      chk("abort_busy", 8'(Busy),        8'd0);
      chk("abort_data", RxData,          8'h81);
      chk("abort_perr", 8'(ParityErr),   8'd1);
      RxEn = 1'b1;
      drive(1'b1, 8 * BIT_T);
      chk("abort_count", 8'(rx_q.size()), 8'd0);
      run_frame("after_abort_FF", 8'hFF, 4'd8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

      // Randomized configurations, data and injected errors.
      for (int k = 0; k < 24; k++) begin
         run_frame($sformatf("rand%0d", k),
                   8'($urandom),
                   4'($urandom_range(0, 15)),
                   2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 3) != 0),
                   1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Parametrised, oversampling UART receiver for the Basys UART path. It takes the raw `Rx` pin and a baud-rate `Tick` enable, and delivers framed bytes with per-frame status. Status covers parity, framing and break. Data width, parity and stop-bit count are selectable at run time; the oversampling factor is set at elaboration. The block runs entirely on `Clk`, with `Tick` used as a clock enable, and feeds the RX FIFO or register interface downstream.

## Interface
- `OVERSAMPLE`, default 16: Ticks per bit; must be even and ≥ 8.
- `Clk` in 1: system clock.
- `Rst_n` in 1: reset, asynchronous, active-low.
- `RxEn` in 1: receiver enable.
- `Rx` in 1: serial line, asynchronous; idle high.
- `Tick` in 1: one-`Clk` pulse at OVERSAMPLE × baud.
- `NBits` in 4: data bits; valid values are 5–8; any other value is treated as 8.
- `Parity` in 2: 00 none, 01 even, 10 odd, 11 treated as none.
- `TwoStop` in 1: 1 = two stop bits.
- `RxData` out 8: received word, LSB-first, right-justified, upper bits zero.
- `RxValid` out 1: one-`Clk` pulse; frame complete.
- `ParityErr`, `FrameErr`, `BreakDet` out 1 each: status for the current frame; valid with `RxValid` and held until the next `RxValid`.
- `Busy` out 1: high whenever state ≠ IDLE.

## Operation
- `Rx` passes through a 2-FF synchroniser, reset value 1. Every later reference to `Rx` means the synchronised value.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2.
- **IDLE → START:** taken on a synchronised falling edge of `Rx` while `RxEn`=1. On entry, `NBits`, `Parity` and `TwoStop` are latched. Later changes to those inputs mid-frame have no effect.
- **Sampling:** each bit is sampled by majority vote of the three Ticks at counts OVERSAMPLE/2−1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The tick counter is $clog2(OVERSAMPLE) bits wide and wraps at OVERSAMPLE−1.
- **START:** a voted value of 1 is a false start; return to IDLE with no output. A voted 0 realigns the counter so that later bits are sampled mid-bit, then moves to DATA.
- **DATA:** shifts in the latched number of bits. Then go to PARITY if parity is enabled, otherwise to STOP1.
- **PARITY:** the check is XOR of the data bits and the parity bit. Even mode expects 0; odd mode expects 1. A mismatch sets `ParityErr`.
- **STOP1:** a voted 0 sets `FrameErr`. If `TwoStop`=1, go to STOP2; a voted 0 there also sets `FrameErr`.
- **Frame end:** `RxValid` pulses and the block returns to IDLE. Re-arming requires a new falling edge, so a line stuck low never retriggers.
- **Break:** all data bits, the parity bit (if enabled) and STOP1 all 0 sets `BreakDet` and `FrameErr` together. `RxData` reports 0.
- **RxEn deasserted mid-frame:** abort to IDLE at the next `Clk`. No `RxValid`; status outputs are unchanged.

## Timing
- **Reset values:** `RxData`=0, `RxValid`=0, `ParityErr`=0, `FrameErr`=0, `BreakDet`=0, `Busy`=0, state IDLE, synchroniser FFs=1.
- **Edge-detect latency:** 2 `Clk` from a pin edge to its synchronised edge.
- **Frame completion:** `RxValid` rises one `Clk` after the `Tick` carrying the final vote sample of the last stop bit. `RxData` and all status outputs update in that same cycle.
- **Handshake:** there is no back-pressure. Consumers must capture data and status on the `RxValid` cycle.
- **Tick and edge together:** a `Tick` coinciding with the falling-edge detect counts as sample 0 of START.
- **Reset mid-frame:** immediate return to IDLE and all outputs to reset values. No `RxValid` is issued for the partial frame.

## Structure
- Package `uart_pkg` holds:
  - the parity-mode enum (NONE, EVEN, ODD);
  - the receiver state enum;
  - `localparam` values for the min/max data bits (5/8).
- Sub-module `uart_rx_sync` contains the 2-FF synchroniser and falling-edge detector. It is reusable by the TX loopback checker.
- The core holds the FSM, tick counter, majority voter, shift register and status registers.

## Test plan
- **8N1, 0x A5:** with `OVERSAMPLE`=16, send 0xA5 → `RxData`=0xA5 and `RxValid` once; all error flags 0.
- **7E1, bad parity:** send 0x55 with the parity bit inverted → `RxData`=0x55 and `ParityErr`=1.
- **8N2, second stop low:** send 0x3C with STOP2 driven low → `RxData`=0x3C and `FrameErr`=1.
- **Glitch:** a 5-Tick low pulse on the idle line → no `RxValid`, `Busy` returns to 0. The next valid frame 0x12 is received correctly.
- **Break:** hold the line low for 20 bit-times → one `RxValid` with `BreakDet`=1, `FrameErr`=1, `RxData`=0. No second frame is reported until the line goes high and a new start bit arrives.
- **Reset and RxEn abort:**
  - Assert `Rst_n`=0 during DATA → all outputs go to zero.
  - Drop `RxEn` in DATA → no `RxValid`.
  - After either, a following 0xFF frame is received cleanly.
